// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the HDMI PLL lock supervisor: state encodings and
// default timing constants at the 50 MHz reference clock.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILISE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 50;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 5000;
  localparam int DEF_MAX_RETRIES         = 7;
  localparam int DEF_CNT_W               = 20;

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser bringing one asynchronous level into the clk domain;
// q follows d with two cycles of latency.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait and lock stabilisation, then releases the
// video-domain reset; retries on lock timeout and latches a fault when exhausted.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       video_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  if (RST_PULSE_CYCLES < 1 || longint'(RST_PULSE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_chk_rst
    $error("RST_PULSE_CYCLES must be in [1, 2**CNT_W)");
  end
  if (LOCK_TIMEOUT_CYCLES < 1 || longint'(LOCK_TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_chk_to
    $error("LOCK_TIMEOUT_CYCLES must be in [1, 2**CNT_W)");
  end
  if (LOCK_STABLE_CYCLES < 1 || longint'(LOCK_STABLE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_chk_st
    $error("LOCK_STABLE_CYCLES must be in [1, 2**CNT_W)");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_chk_retry
    $error("MAX_RETRIES must fit in 4 bits");
  end

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             locked_s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       retry_nx;
  logic [7:0]       loss_nx;
  logic             restart;
  logic             pll_rst_nx, video_rst_nx, ready_nx, fault_nx;

  sync_2ff u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RESET_PLL;
      cnt             <= '0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
      pll_rst         <= 1'b1;
      video_rst       <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      retry_count     <= retry_nx;
      lock_loss_count <= loss_nx;
      pll_rst         <= pll_rst_nx;
      video_rst       <= video_rst_nx;
      ready           <= ready_nx;
      fault           <= fault_nx;
    end
  end

  // A relock request overrides every state transition, including a timeout.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    retry_nx = retry_count;
    loss_nx  = lock_loss_count;
    if (force_relock) begin
      state_nx = RESET_PLL;
      restart  = 1'b1;
      retry_nx = 4'd0;
    end else begin
      case (state)
        RESET_PLL: if (cnt == RST_LAST) state_nx = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nx = STABILISE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_count == RETRY_MAX) begin
              state_nx = FAULT;
            end else begin
              retry_nx = retry_count + 4'd1;
              state_nx = RESET_PLL;
            end
          end
        end
        STABILISE: begin
          if (!locked_s) begin
            state_nx = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nx = RUN;
            retry_nx = 4'd0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            loss_nx  = sat_inc8(lock_loss_count);
            state_nx = RESET_PLL;
          end
        end
        FAULT:   state_nx = FAULT;
        default: state_nx = RESET_PLL;
      endcase
    end
    // RUN and FAULT have no timed exit, so their count is frozen.
    if (restart || state_nx != state) begin
      cnt_nx = '0;
    end else if (state == RUN || state == FAULT) begin
      cnt_nx = cnt;
    end else begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_comb begin
    pll_rst_nx   = (state_nx == RESET_PLL);
    video_rst_nx = (state_nx != RUN);
    ready_nx     = (state_nx == RUN);
    fault_nx     = (state_nx == FAULT);
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a behavioural model.
module tb_pll_lock_supervisor;

  localparam int P_RST     = 4;
  localparam int P_TIMEOUT = 20;
  localparam int P_STABLE  = 8;
  localparam int P_RETRIES = 2;

  localparam int M_RST   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_STAB  = 2;
  localparam int M_RUN   = 3;
  localparam int M_FAULT = 4;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       video_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  // behavioural model: phase, cycles spent in phase, and the pin history
  int m_ph = M_RST;
  int m_t = 0;
  int m_retry = 0;
  int m_loss = 0;
  bit m_d1 = 1'b0;
  bit m_d2 = 1'b0;

  typedef struct {
    int n;
    bit rst;
    bit pin;
    bit frc;
    bit pll_rst;
    bit video_rst;
    bit ready;
    bit fault;
    int retry;
    int loss;
  } vec_t;

  vec_t tbl[$];

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (P_RST),
    .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .MAX_RETRIES         (P_RETRIES),
    .CNT_W               (20)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .force_relock    (force_relock),
    .pll_rst         (pll_rst),
    .video_rst       (video_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dut_vec();
    return {pll_rst, video_rst, ready, fault, retry_count, lock_loss_count};
  endfunction

  function automatic logic [15:0] pack_exp(bit pr, bit vr, bit rd, bit ft, int rc, int lc);
    return {pr, vr, rd, ft, 4'(rc), 8'(lc)};
  endfunction

  function automatic logic [15:0] model_vec();
    return pack_exp(m_ph == M_RST, m_ph != M_RUN, m_ph == M_RUN, m_ph == M_FAULT,
                    m_retry, m_loss);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (pll_rst,video_rst,ready,fault,retry,loss)",
               name, act, exp);
    end
  endtask

  // One clock edge of the supervisor as the rules describe it.
  task automatic model_step(input bit r, input bit pin, input bit frc);
    bit ls;
    int nxt;
    ls = m_d2;
    if (r) begin
      m_d1 = 1'b0; m_d2 = 1'b0;
      m_ph = M_RST; m_t = 0; m_retry = 0; m_loss = 0;
    end else begin
      m_d2 = m_d1;
      m_d1 = pin;
      nxt = m_ph;
      if (frc) begin
        nxt = M_RST;
        m_retry = 0;
      end else begin
        case (m_ph)
          M_RST:  if (m_t + 1 == P_RST) nxt = M_WAIT;
          M_WAIT: begin
            if (ls) nxt = M_STAB;
            else if (m_t + 1 == P_TIMEOUT) begin
              if (m_retry == P_RETRIES) nxt = M_FAULT;
              else begin
                m_retry++;
                nxt = M_RST;
              end
            end
          end
          M_STAB: begin
            if (!ls) nxt = M_WAIT;
            else if (m_t + 1 == P_STABLE) begin
              nxt = M_RUN;
              m_retry = 0;
            end
          end
          M_RUN: begin
            if (!ls) begin
              if (m_loss < 255) m_loss++;
              nxt = M_RST;
            end
          end
          default: ;
        endcase
      end
      if (frc || nxt != m_ph) m_t = 0;
      else m_t++;
      m_ph = nxt;
    end
  endtask

  task automatic tick(input bit r, input bit pin, input bit frc);
    rst = r;
    pll_locked = pin;
    force_relock = frc;
    @(posedge clk);
    model_step(r, pin, frc);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic add(input int n, input bit r, input bit pin, input bit frc,
                     input bit pr, input bit vr, input bit rd, input bit ft,
                     input int rc, input int lc);
    vec_t v;
    v.n = n; v.rst = r; v.pin = pin; v.frc = frc;
    v.pll_rst = pr; v.video_rst = vr; v.ready = rd; v.fault = ft;
    v.retry = rc; v.loss = lc;
    tbl.push_back(v);
  endtask

  initial begin
    int k;
    bit pin;
    bit frc;
    bit r;
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;

    // clean start, first loss in RUN
    add(2,  1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(3,  0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(6,  0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(10, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1,  0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(2,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1,  0, 0, 0, 1, 1, 0, 0, 0, 1);
    // never lock: three pulses then fault
    add(1,  1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(4,  0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(19, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1,  0, 0, 0, 1, 1, 0, 0, 1, 0);
    add(4,  0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(19, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(1,  0, 0, 0, 1, 1, 0, 0, 2, 0);
    add(23, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    add(1,  0, 0, 0, 0, 1, 0, 1, 2, 0);
    add(10, 0, 0, 0, 0, 1, 0, 1, 2, 0);
    // relock out of fault, then relock on the timeout cycle
    add(1,  0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(3,  0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(19, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1,  0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(4,  0, 0, 0, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) tick(tbl[i].rst, tbl[i].pin, tbl[i].frc);
      check($sformatf("table row %0d", i), dut_vec(),
            pack_exp(tbl[i].pll_rst, tbl[i].video_rst, tbl[i].ready, tbl[i].fault,
                     tbl[i].retry, tbl[i].loss));
    end

    // glitch of two cycles while stabilising
    tick(1, 1, 0);
    for (int c = 0; c < 10; c++) tick(0, 1, 0);
    for (int c = 0; c < 2; c++) tick(0, 0, 0);
    for (int c = 0; c < 10; c++) tick(0, 1, 0);
    check("glitch not yet ready", dut_vec(), pack_exp(0, 1, 0, 0, 0, 0));
    tick(0, 1, 0);
    check("glitch then ready", dut_vec(), pack_exp(0, 0, 1, 0, 0, 0));

    // repeated lock losses, counter saturates
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, 0);
      tick(0, 0, 0);
      check("loss video_rst still low", 16'(video_rst), 16'd0);
      tick(0, 0, 0);
      check("loss video_rst and count", {7'd0, video_rst, lock_loss_count},
            {7'd0, 1'b1, 8'((i + 1 > 255) ? 255 : i + 1)});
      k = 0;
      while (ready !== 1'b1 && k < 60) begin
        tick(0, 1, 0);
        k++;
      end
      check("recover within bound", 16'(ready), 16'd1);
    end
    check("loss count saturated", 16'(lock_loss_count), 16'd255);

    // rst in the middle of stabilisation
    for (int c = 0; c < 3; c++) tick(0, 0, 0);
    for (int c = 0; c < 7; c++) tick(0, 1, 0);
    check("mid stabilise", dut_vec(), pack_exp(0, 1, 0, 0, 0, 255));
    tick(1, 1, 0);
    check("rst mid stabilise", dut_vec(), pack_exp(1, 1, 0, 0, 0, 0));

    // randomized run against the model
    pin = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29, 0) == 0) pin = ~pin;
      frc = ($urandom_range(149, 0) == 0);
      r = ($urandom_range(799, 0) == 0);
      tick(r, pin, frc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
